// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared types and helpers for the 4x4 matrix keypad scanner.
//   state_t    : scanner FSM states
//   KEY_*      : codes for the operator and symbol keys
//   key_code() : maps a (row index, column index) pair to the 4-bit key code
//   col_index(): encodes a one-low column pattern to a 2-bit column index
// -----------------------------------------------------------------------------
package keypad_pkg;

    typedef enum logic [2:0] {
        SCAN,
        DEBOUNCE,
        PRESS,
        HELD,
        RELEASE
    } state_t;

    localparam logic [3:0] KEY_ADD  = 4'd10;
    localparam logic [3:0] KEY_SUB  = 4'd11;
    localparam logic [3:0] KEY_MUL  = 4'd12;
    localparam logic [3:0] KEY_DIV  = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    // Keypad layout, row r / column c:
    //   r0: 1 2 3 A    r1: 4 5 6 B    r2: 7 8 9 C    r3: * 0 # D
    function automatic logic [3:0] key_code(input logic [1:0] row_idx,
                                            input logic [1:0] col_idx);
        logic [3:0] code;
        code = 4'd0;
        case ({row_idx, col_idx})
            4'h0: code = 4'd1;
            4'h1: code = 4'd2;
            4'h2: code = 4'd3;
            4'h3: code = KEY_ADD;
            4'h4: code = 4'd4;
            4'h5: code = 4'd5;
            4'h6: code = 4'd6;
            4'h7: code = KEY_SUB;
            4'h8: code = 4'd7;
            4'h9: code = 4'd8;
            4'hA: code = 4'd9;
            4'hB: code = KEY_MUL;
            4'hC: code = KEY_STAR;
            4'hD: code = 4'd0;
            4'hE: code = KEY_HASH;
            4'hF: code = KEY_DIV;
            default: code = 4'd0;
        endcase
        return code;
    endfunction

    // Column sense is active-low; the candidate holds exactly one low bit.
    function automatic logic [1:0] col_index(input logic [3:0] col_n);
        logic [1:0] idx;
        idx = 2'd0;
        case (col_n)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/kp_sync2.sv
// -----------------------------------------------------------------------------
// kp_sync2
// Two-flop synchronizer for asynchronous inputs. Resets to all-ones so that
// pulled-up, active-low inputs read as idle straight out of reset.
//   clk      : destination clock
//   rst_n    : asynchronous active-low reset
//   i_async  : [WIDTH] asynchronous input
//   o_sync   : [WIDTH] input synchronized to clk (2-cycle latency)
// -----------------------------------------------------------------------------
module kp_sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Row-scanning driver for a 4x4 matrix keypad with debounced press/release.
// Emits a single-cycle key_flag per accepted press together with its code.
//   clk      : clock
//   rst_n    : asynchronous active-low reset
//   row      : [4] row drive, active-low, exactly one bit low
//   col      : [4] column sense, active-low, asynchronous to clk
//   key_flag : one-cycle strobe per accepted press
//   key_data : [4] code of the last accepted key, held until the next press
//   key_held : high from the key_flag cycle until the release is accepted
// -----------------------------------------------------------------------------
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int DEB_TICKS = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] row,
    input  logic [3:0] col,
    output logic       key_flag,
    output logic [3:0] key_data,
    output logic       key_held
);

    localparam int TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W  = $clog2(DEB_TICKS + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEB_TICKS);
    localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);

    logic [3:0]        w_col_s;
    logic [TICK_W-1:0] r_tick_cnt;
    logic              w_tick;

    state_t            r_state,     w_state_nxt;
    logic [3:0]        r_row,       w_row_nxt;
    logic [1:0]        r_row_idx,   w_row_idx_nxt;
    logic [DEB_W-1:0]  r_deb_cnt,   w_deb_nxt;
    logic [3:0]        r_cand_col,  w_cand_nxt;
    logic              r_key_flag,  w_flag_nxt;
    logic [3:0]        r_key_data,  w_data_nxt;
    logic              r_key_held,  w_held_nxt;

    logic [3:0]        w_col_low;
    logic              w_released;
    logic              w_single;
    logic [DEB_W-1:0]  w_deb_inc;
    logic              w_rotate;

    kp_sync2 #(.WIDTH(4)) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (col),
        .o_sync  (w_col_s)
    );

    // Free-running scan tick: one tick every SCAN_DIV cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
        end
    end

    assign w_tick     = (r_tick_cnt == TICK_LAST);
    assign w_col_low  = ~w_col_s;
    assign w_released = (w_col_s == 4'b1111);
    // Exactly one column low: non-zero and a power of two.
    assign w_single   = (w_col_low != 4'd0) && ((w_col_low & (w_col_low - 4'd1)) == 4'd0);
    assign w_deb_inc  = r_deb_cnt + DEB_ONE;

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt   = r_state;
        w_row_nxt     = r_row;
        w_row_idx_nxt = r_row_idx;
        w_deb_nxt     = r_deb_cnt;
        w_cand_nxt    = r_cand_col;
        w_flag_nxt    = 1'b0;
        w_data_nxt    = r_key_data;
        w_held_nxt    = r_key_held;
        w_rotate      = 1'b0;

        case (r_state)
            SCAN: begin
                if (w_tick) begin
                    if (w_single) begin
                        w_cand_nxt  = w_col_s;
                        w_deb_nxt   = DEB_ONE;
                        w_state_nxt = DEBOUNCE;
                    end else begin
                        // Idle or ghosted multi-key: keep scanning.
                        w_rotate = 1'b1;
                    end
                end
            end

            DEBOUNCE: begin
                // The entry sample alone can already satisfy DEB_TICKS == 1.
                if (r_deb_cnt == DEB_MAX) begin
                    w_state_nxt = PRESS;
                end else if (w_tick) begin
                    if (w_col_s == r_cand_col) begin
                        w_deb_nxt = w_deb_inc;
                        if (w_deb_inc == DEB_MAX) begin
                            w_state_nxt = PRESS;
                        end
                    end else begin
                        w_deb_nxt   = '0;
                        w_state_nxt = SCAN;
                        w_rotate    = 1'b1;
                    end
                end
            end

            PRESS: begin
                w_state_nxt = HELD;
            end

            HELD: begin
                if (w_tick && w_released) begin
                    w_deb_nxt   = DEB_ONE;
                    w_state_nxt = RELEASE;
                end
            end

            RELEASE: begin
                if (r_deb_cnt == DEB_MAX) begin
                    w_deb_nxt   = '0;
                    w_held_nxt  = 1'b0;
                    w_state_nxt = SCAN;
                    w_rotate    = 1'b1;
                end else if (w_tick) begin
                    if (w_released) begin
                        w_deb_nxt = w_deb_inc;
                        if (w_deb_inc == DEB_MAX) begin
                            w_deb_nxt   = '0;
                            w_held_nxt  = 1'b0;
                            w_state_nxt = SCAN;
                            w_rotate    = 1'b1;
                        end
                    end else begin
                        // Bounce on release: back to HELD, no new strobe.
                        w_deb_nxt   = '0;
                        w_state_nxt = HELD;
                    end
                end
            end

            default: begin
                w_state_nxt = SCAN;
            end
        endcase

        // Outputs are registered on entry to PRESS so flag, data and held
        // all change in the PRESS cycle itself.
        if (w_state_nxt == PRESS) begin
            w_flag_nxt = 1'b1;
            w_data_nxt = key_code(r_row_idx, col_index(r_cand_col));
            w_held_nxt = 1'b1;
            w_deb_nxt  = '0;
        end

        if (w_rotate) begin
            w_row_nxt     = {r_row[2:0], r_row[3]};
            w_row_idx_nxt = r_row_idx + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= SCAN;
            r_row      <= 4'b1110;
            r_row_idx  <= 2'd0;
            r_deb_cnt  <= '0;
            r_cand_col <= 4'b1111;
            r_key_flag <= 1'b0;
            r_key_data <= 4'd0;
            r_key_held <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_row      <= w_row_nxt;
            r_row_idx  <= w_row_idx_nxt;
            r_deb_cnt  <= w_deb_nxt;
            r_cand_col <= w_cand_nxt;
            r_key_flag <= w_flag_nxt;
            r_key_data <= w_data_nxt;
            r_key_held <= w_held_nxt;
        end
    end

    assign row      = r_row;
    assign key_flag = r_key_flag;
    assign key_data = r_key_data;
    assign key_held = r_key_held;

endmodule
